// File: rtl/pwm_peripheral.sv
// 16-channel PWM/static output block fed by the SPI configuration registers.
// Duty is shadowed and only reloaded at the period wrap, so a period is never cut short or stretched.
module pwm_peripheral #(
  parameter int PRESCALE = 3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        pwm_cycle_start
);

  localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_MAX  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]   PRE_ONE  = PW'(1);
  localparam logic [7:0]      CNT_LAST = 8'd254;

  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;
  logic [7:0]    duty_sh_q, duty_sh_d;
  logic [15:0]   out_q, out_d;
  logic          pwm_cycle_start_q, pwm_cycle_start_d;

  logic          tick;
  logic          wrap;
  logic          pwm_raw;
  logic [15:0]   en_out;
  logic [15:0]   en_pwm;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  always_comb begin
    tick      = (pre_cnt_q == PRE_MAX);
    wrap      = tick && (pwm_cnt_q == CNT_LAST);
    pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_ONE;

    pwm_cnt_d = pwm_cnt_q;
    if (tick) begin
      pwm_cnt_d = wrap ? 8'd0 : pwm_cnt_q + 8'd1;
    end

    duty_sh_d = wrap ? pwm_duty_cycle : duty_sh_q;

    // 0xFF is forced high because the counter never reaches 255.
    pwm_raw = (duty_sh_q == 8'hFF) || (pwm_cnt_q < duty_sh_q);

    out_d             = en_out & (~en_pwm | {16{pwm_raw}});
    pwm_cycle_start_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q         <= '0;
      pwm_cnt_q         <= 8'd0;
      duty_sh_q         <= 8'd0;
      out_q             <= 16'd0;
      pwm_cycle_start_q <= 1'b0;
    end else begin
      pre_cnt_q         <= pre_cnt_d;
      pwm_cnt_q         <= pwm_cnt_d;
      duty_sh_q         <= duty_sh_d;
      out_q             <= out_d;
      pwm_cycle_start_q <= pwm_cycle_start_d;
    end
  end

  assign out             = out_q;
  assign pwm_cycle_start = pwm_cycle_start_q;

endmodule
